// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, read-size
// encodings and the latency LFSR polynomial.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] RB_BYTE = 2'd0;
  localparam logic [1:0] RB_HALF = 2'd1;
  localparam logic [1:0] RB_WORD = 2'd2;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0].
  localparam logic [7:0] LFSR_SEED = 8'h5A;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mem_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR that supplies pseudo-random response latency.
module lfsr8
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= LFSR_SEED;
    end else begin
      out <= {out[6:0], ^(out & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits a fixed or
// LFSR-drawn latency, performs a masked write or sized read, then holds the response.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RAND_LAT  = 1,
  parameter int          FIXED_LAT = 1,
  parameter logic [3:0]  LAT_MASK  = 4'h7
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  input  logic [1:0]  req_rbyte_num,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_t      state;
  logic [4:0]  cnt;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic [1:0]  rb_q;

  logic [7:0]  lfsr;
  logic        lfsr_unused;
  logic [4:0]  lat;
  logic        commit;

  logic [31:0] idx;
  logic        in_range;
  logic        misaligned;
  logic        err_c;
  logic [31:0] word_sh;
  logic [31:0] rdata_c;

  logic [31:0] mem [MEM_WORDS];

  lfsr8 u_lfsr (
    .clk (sys_clk),
    .rst (sys_rst),
    .out (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:4];

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign commit     = (state == ST_WAIT) && (cnt == 5'd1);

  always_comb begin
    if (RAND_LAT != 0) begin
      lat = 5'd1 + {1'b0, lfsr[3:0] & LAT_MASK};
    end else begin
      lat = 5'(FIXED_LAT);
    end
  end

  // Subtraction wraps, so addresses below the base land far out of range.
  always_comb begin
    idx        = (addr_q - BASE_ADDR) >> 2;
    in_range   = (addr_q >= BASE_ADDR) && (idx < 32'(MEM_WORDS));
    misaligned = 1'b0;
    case (rb_q)
      RB_BYTE: misaligned = 1'b0;
      RB_HALF: misaligned = addr_q[0];
      default: misaligned = (addr_q[1:0] != 2'b00);
    endcase
    err_c   = !in_range || (!wen_q && misaligned);
    word_sh = mem[idx[AW-1:0]] >> {addr_q[1:0], 3'b000};
    rdata_c = 32'h0;
    if (!err_c && !wen_q) begin
      case (rb_q)
        RB_BYTE: rdata_c = {24'h0, word_sh[7:0]};
        RB_HALF: rdata_c = {16'h0, word_sh[15:0]};
        default: rdata_c = word_sh;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      cnt        <= 5'd0;
      wen_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 4'h0;
      rb_q       <= RB_BYTE;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            rb_q    <= req_rbyte_num;
            cnt     <= lat;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            resp_rdata <= rdata_c;
            resp_err   <= err_c;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array has no reset; a reset forces the FSM to idle so no commit can follow.
  always_ff @(posedge sys_clk) begin
    if (commit && wen_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask_q[b]) begin
          mem[idx[AW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a fixed-latency instance for directed cases and a
// random-latency instance driven by random traffic, both checked every cycle.
module tb_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int MW0 = 4096;
  localparam int MW1 = 64;

  logic        clk = 1'b0;
  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_wen      [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [3:0]  req_wmask    [2];
  logic [1:0]  req_rb       [2];
  logic        resp_ready   [2];
  logic        req_ready_o  [2];
  logic        resp_valid_o [2];
  logic [31:0] rdata_o      [2];
  logic        err_o        [2];

  logic        exp_ready [2];
  logic        exp_valid [2];
  logic [31:0] exp_rdata [2];
  logic        exp_err   [2];
  logic        chk_data  [2];
  logic        chk_en = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mlfsr;
  logic [31:0] mm0 [int unsigned];
  logic [31:0] mm1 [int unsigned];

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_WORDS(MW0), .BASE_ADDR(BASE), .RAND_LAT(0), .FIXED_LAT(3), .LAT_MASK(4'h7)
  ) u_fix (
    .sys_clk(clk), .sys_rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready_o[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .req_rbyte_num(req_rb[0]), .resp_valid(resp_valid_o[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(rdata_o[0]), .resp_err(err_o[0])
  );

  mem_responder #(
    .MEM_WORDS(MW1), .BASE_ADDR(BASE), .RAND_LAT(1), .FIXED_LAT(1), .LAT_MASK(4'h7)
  ) u_rnd (
    .sys_clk(clk), .sys_rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready_o[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .req_rbyte_num(req_rb[1]), .resp_valid(resp_valid_o[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(rdata_o[1]), .resp_err(err_o[1])
  );

  function automatic logic [7:0] lfsr_next(logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always @(posedge clk) mlfsr <= rst[1] ? 8'h5A : lfsr_next(mlfsr);

  function automatic logic [31:0] mrd(int d, int unsigned i);
    if (d == 0) return mm0.exists(i) ? mm0[i] : 32'h0;
    return mm1.exists(i) ? mm1[i] : 32'h0;
  endfunction

  task automatic mwr(int d, int unsigned i, logic [31:0] v);
    if (d == 0) mm0[i] = v;
    else mm1[i] = v;
  endtask

  // Transaction-level reference: range/alignment rules and sized, shifted reads.
  task automatic model(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [1:0] rb, output logic [31:0] rd, output logic e);
    int unsigned mw  = (d == 0) ? MW0 : MW1;
    logic [31:0] off = addr - BASE;
    int unsigned idx = off / 4;
    logic        oor = (addr < BASE) || (idx >= mw);
    logic        mis = !wen && ((rb == 2'd1 && addr % 2 != 0) || (rb >= 2'd2 && addr % 4 != 0));
    logic [31:0] w;
    e  = oor || mis;
    rd = 32'h0;
    if (!e) begin
      w = mrd(d, idx);
      if (wen) begin
        for (int b = 0; b < 4; b++) if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mwr(d, idx, w);
      end else begin
        rd = w >> (8 * (addr % 4));
        if (rb == 2'd0) rd = rd & 32'hFF;
        else if (rb == 2'd1) rd = rd & 32'hFFFF;
      end
    end
  endtask

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("req_ready", d, {31'b0, req_ready_o[d]}, {31'b0, exp_ready[d]});
        chk("resp_valid", d, {31'b0, resp_valid_o[d]}, {31'b0, exp_valid[d]});
        if (exp_valid[d] || chk_data[d]) begin
          chk("resp_rdata", d, rdata_o[d], exp_rdata[d]);
          chk("resp_err", d, {31'b0, err_o[d]}, {31'b0, exp_err[d]});
        end
      end
    end
  end

  // Called just after a rising edge with the instance idle; returns the same way.
  task automatic xact(int d, logic wen, logic [31:0] addr, logic [31:0] wdata,
                      logic [3:0] wmask, logic [1:0] rb, int hold, logic keep,
                      logic use_lit, logic [31:0] lit_rd, logic lit_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    lat = (d == 0) ? 3 : 1 + int'(mlfsr[3:0] & 4'h7);
    model(d, wen, addr, wdata, wmask, rb, rd, e);
    if (use_lit) begin
      rd = lit_rd;
      e  = lit_err;
    end
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = wmask;
    req_rb[d]    = rb;
    @(posedge clk); #1;
    chk_data[d]  = 1'b0;
    exp_ready[d] = 1'b0;
    if (keep) begin
      req_wdata[d] = $urandom;
      req_addr[d]  = BASE + 32'($urandom_range(0, 15)) * 4;
      req_wen[d]   = 1'b1;
      req_wmask[d] = 4'hF;
    end else begin
      req_valid[d] = 1'b0;
    end
    repeat (lat) @(posedge clk);
    #1;
    exp_valid[d] = 1'b1;
    exp_rdata[d] = rd;
    exp_err[d]   = e;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    exp_valid[d]  = 1'b0;
    exp_ready[d]  = 1'b1;
  endtask

  function automatic int unsigned pool_idx(int j);
    return (j < 8) ? j : MW1 - 16 + j;
  endfunction

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_wmask[d] = 4'h0; req_rb[d] = 2'd0; resp_ready[d] = 1'b0;
      exp_ready[d] = 1'b1; exp_valid[d] = 1'b0; exp_rdata[d] = 32'h0; exp_err[d] = 1'b0;
      chk_data[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;

    // Directed cases on the fixed-latency (3 cycle) instance.
    xact(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'd2, 0, 0, 1, 32'h0, 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'hDEAD_BEEF, 0);
    xact(0, 1, 32'h8000_0011, 32'h0000_AA00, 4'b0010, 2'd0, 1, 0, 1, 32'h0, 0);
    xact(0, 0, 32'h8000_0011, 32'h0, 4'h0, 2'd0, 0, 0, 1, 32'h0000_00AA, 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'hDEAD_AAEF, 0);
    xact(0, 0, 32'h8000_0012, 32'h0, 4'h0, 2'd1, 0, 0, 1, 32'h0000_DEAD, 0);
    xact(0, 0, 32'h8000_0013, 32'h0, 4'h0, 2'd1, 0, 0, 1, 32'h0, 1);
    xact(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'h0, 1);
    xact(0, 0, 32'h8000_4000, 32'h0, 4'h0, 2'd3, 0, 0, 1, 32'h0, 1);
    xact(0, 1, 32'h8000_3FFC, 32'h1234_5678, 4'hF, 2'd0, 0, 0, 1, 32'h0, 0);
    xact(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'd0, 0, 0, 1, 32'h0, 0);
    xact(0, 1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'd2, 0, 0, 1, 32'h0, 1);
    xact(0, 1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 2'd2, 0, 0, 1, 32'h0, 1);
    xact(0, 0, 32'h8000_3FFC, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'h1234_5678, 0);
    xact(0, 0, 32'h8000_0000, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'hCAFE_F00D, 0);
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 2'd2, 5, 1, 1, 32'hDEAD_AAEF, 0);

    // Reset during the wait phase of a write must drop the write.
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0010;
    req_wdata[0] = 32'h0BAD_F00D; req_wmask[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; chk_data[0] = 1'b0; exp_ready[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    exp_ready[0] = 1'b1; exp_valid[0] = 1'b0; exp_rdata[0] = 32'h0; exp_err[0] = 1'b0;
    chk_data[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xact(0, 0, 32'h8000_0010, 32'h0, 4'h0, 2'd2, 0, 0, 1, 32'hDEAD_AAEF, 0);

    // Random traffic on the LFSR-latency instance.
    for (int j = 0; j < 16; j++) begin
      xact(1, 1, BASE + pool_idx(j) * 4, $urandom, 4'hF, 2'd2, 0, 0, 0, 32'h0, 0);
    end
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + MW1 * 4 + 32'($urandom_range(0, 15));
      else a = BASE + pool_idx($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      xact(1, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           0, 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int j = 0; j < 16; j++) begin
      xact(1, 0, BASE + pool_idx(j) * 4, 32'h0, 4'h0, 2'd2, 0, 0, 0, 32'h0, 0);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
